truth_table_checker: RTL and testbench

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

---
 rtl/truth_table_checker.sv | 104 ++++++++++
 tb/tb_truth_table_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Exhaustive 3-input truth-table checker: drives eight fixed vectors to a DUT,
// waits SETTLE cycles per vector and counts responses that differ from a|b.
module truth_table_checker #(
    parameter int unsigned SETTLE       = 2,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       x,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_cnt,
    output logic [2:0] first_fail_idx
);

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;

    localparam logic [3:0] WAIT_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t     r_state, w_next;
    logic [2:0] r_idx;
    logic [3:0] r_wait;
    logic       w_x_exp, w_y_exp, w_mismatch, w_stop;

    // Vector order as {a,b,c}: single-bit patterns before pairs.
    function automatic logic [2:0] vec(input logic [2:0] i);
        case (i)
            3'd0:    vec = 3'b000;
            3'd1:    vec = 3'b100;
            3'd2:    vec = 3'b010;
            3'd3:    vec = 3'b001;
            3'd4:    vec = 3'b110;
            3'd5:    vec = 3'b101;
            3'd6:    vec = 3'b011;
            default: vec = 3'b111;
        endcase
    endfunction

    assign w_x_exp    = (a & ~c) | ~(a | ~b) | (c & ~(c & ~a));
    assign w_y_exp    = a | b;
    assign w_mismatch = (x != w_x_exp) || (y != w_y_exp);
    assign w_stop     = (r_idx == 3'd7) || (w_mismatch && STOP_ON_FAIL);

    assign busy = (r_state == APPLY) || (r_state == WAIT) || (r_state == CHECK);
    assign done = (r_state == DONE);
    assign pass = done && (fail_cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = APPLY;
            APPLY:      w_next = (SETTLE == 0) ? CHECK : WAIT;
            WAIT:       if (r_wait == WAIT_LAST) w_next = CHECK;
            CHECK:      w_next = w_stop ? DONE : APPLY;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {a, b, c}      <= 3'b000;
            r_idx          <= 3'd0;
            r_wait         <= 4'd0;
            fail_cnt       <= 4'd0;
            first_fail_idx <= 3'd0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_idx          <= 3'd0;
                        fail_cnt       <= 4'd0;
                        first_fail_idx <= 3'd0;
                    end
                end
                APPLY: begin
                    {a, b, c} <= vec(r_idx);
                    r_wait    <= 4'd0;
                end
                WAIT: r_wait <= r_wait + 4'd1;
                CHECK: begin
                    if (w_mismatch) begin
                        fail_cnt <= fail_cnt + 4'd1;
                        if (fail_cnt == 4'd0) first_fail_idx <= r_idx;
                    end
                    // idx stays on the final vector so DONE reports where the run ended
                    if (!w_stop) r_idx <= r_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench: three checker configurations driving a modelled combinational DUT
// with selectable faults; run results are scoreboarded against a table.
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_v = '0;
    logic [2:0] x_v, y_v;
    logic [2:0] a_v, b_v, c_v, busy_v, done_v, pass_v;
    logic [3:0] fc_v [3];
    logic [2:0] ffi_v [3];
    int         mode_v [3] = '{0, 0, 0};

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    truth_table_checker #(.SETTLE(2), .STOP_ON_FAIL(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .x(x_v[0]), .y(y_v[0]),
        .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .fail_cnt(fc_v[0]), .first_fail_idx(ffi_v[0]));
    truth_table_checker #(.SETTLE(2), .STOP_ON_FAIL(1'b1)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .x(x_v[1]), .y(y_v[1]),
        .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .fail_cnt(fc_v[1]), .first_fail_idx(ffi_v[1]));
    truth_table_checker #(.SETTLE(0), .STOP_ON_FAIL(1'b0)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .x(x_v[2]), .y(y_v[2]),
        .a(a_v[2]), .b(b_v[2]), .c(c_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .fail_cnt(fc_v[2]), .first_fail_idx(ffi_v[2]));

    // Modelled DUT: mode 0 golden, 1 x stuck-at-0, 2 y inverted on abc=001
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            x_v[i] = (mode_v[i] == 1) ? 1'b0 : (a_v[i] | b_v[i]);
            y_v[i] = (a_v[i] | b_v[i]) ^
                     ((mode_v[i] == 2) && ({a_v[i], b_v[i], c_v[i]} == 3'b001));
        end
    end

    typedef struct {
        int         inst;
        int         settle;
        int         mode;
        bit         extra_start;
        int         edges;
        int         fc;
        int         ffi;
        bit         pass;
        logic [2:0] abc;
    } run_t;

    run_t       tbl [7];
    run_t       sb_q [$];
    logic [2:0] vecs [8] = '{3'b000, 3'b100, 3'b010, 3'b001,
                             3'b110, 3'b101, 3'b011, 3'b111};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input int i, input string nm);
        chk({nm, "_abc"}, {a_v[i], b_v[i], c_v[i]}, 0);
        chk({nm, "_busy"}, busy_v[i], 0);
        chk({nm, "_done"}, done_v[i], 0);
        chk({nm, "_pass"}, pass_v[i], 0);
        chk({nm, "_fc"}, fc_v[i], 0);
        chk({nm, "_ffi"}, ffi_v[i], 0);
    endtask

    // Pulse start; count edges after the sampling edge until done rises.
    task automatic run(input run_t r);
        run_t exp;
        int   e;
        int   i;
        i = r.inst;
        mode_v[i] = r.mode;
        @(negedge clk);
        start_v[i] = 1'b1;
        sb_q.push_back(r);
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        chk("busy_after_start", busy_v[i], 1);
        e = 0;
        while (!done_v[i] && e < 200) begin
            if (r.extra_start && (e == 4 || e == 19)) start_v[i] = 1'b1;
            @(posedge clk); #1;
            start_v[i] = 1'b0;
            e++;
            if (!done_v[i] && (e - 1) % (r.settle + 2) == 0 && (e - 1) / (r.settle + 2) < 8)
                chk("abc_step", {a_v[i], b_v[i], c_v[i]}, vecs[(e - 1) / (r.settle + 2)]);
        end
        exp = sb_q.pop_front();
        chk("done_edge", e, exp.edges);
        chk("done", done_v[i], 1);
        chk("busy_end", busy_v[i], 0);
        chk("fail_cnt", fc_v[i], exp.fc);
        chk("first_fail_idx", ffi_v[i], exp.ffi);
        chk("pass", pass_v[i], exp.pass);
        chk("abc_final", {a_v[i], b_v[i], c_v[i]}, exp.abc);
    endtask

    initial begin
        int e;
        //           inst settle mode extra edges fc ffi pass abc
        tbl[0] = '{0, 2, 0, 1'b1, 32, 0, 0, 1'b1, 3'b111};
        tbl[1] = '{0, 2, 1, 1'b0, 32, 6, 1, 1'b0, 3'b111};
        tbl[2] = '{1, 2, 1, 1'b0,  8, 1, 1, 1'b0, 3'b100};
        tbl[3] = '{1, 2, 0, 1'b0, 32, 0, 0, 1'b1, 3'b111};
        tbl[4] = '{1, 2, 2, 1'b0, 16, 1, 3, 1'b0, 3'b001};
        tbl[5] = '{2, 0, 0, 1'b0, 16, 0, 0, 1'b1, 3'b111};
        tbl[6] = '{2, 0, 2, 1'b0, 16, 1, 3, 1'b0, 3'b111};

        #2;
        for (int i = 0; i < 3; i++) chk_idle(i, "reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_start_busy", busy_v[0], 0);

        for (int k = 0; k < 7; k++) begin
            run(tbl[k]);
            // After the stuck-x run, start again from DONE with a healthy DUT
            if (k == 1) begin
                mode_v[0] = 0;
                @(negedge clk);
                start_v[0] = 1'b1;
                @(posedge clk); #1;
                start_v[0] = 1'b0;
                chk("restart_done_cleared", done_v[0], 0);
                chk("restart_busy", busy_v[0], 1);
                chk("restart_fc_cleared", fc_v[0], 0);
                chk("restart_ffi_cleared", ffi_v[0], 0);
                e = 0;
                while (!done_v[0] && e < 200) begin
                    @(posedge clk); #1;
                    e++;
                end
                chk("restart_done_edge", e, 32);
                chk("restart_pass", pass_v[0], 1);
            end
        end

        // Reset in the middle of a run aborts it with nothing retained
        mode_v[0] = 1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrun_fc_nonzero", (fc_v[0] != 0), 1);
        rst = 1'b1;
        #1;
        chk_idle(0, "midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", busy_v[0] | done_v[0], 0);
        run(tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
